// File: rtl/cube_block_sum_if.sv
// Valid/ready stream bundle between the cube pipeline, the block summer and
// the result sink, plus the per-block length control.
interface cube_block_sum_if #(
   parameter int DATA_W = 32,
   parameter int ACC_W  = 40,
   parameter int LEN_W  = 9
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [LEN_W-1:0]  block_len;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;
   logic              out_ovf;

   modport master (
      output in_valid, in_data, block_len, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf
   );

   modport slave (
      input  in_valid, in_data, block_len, out_ready,
      output in_ready, out_valid, out_sum, out_ovf
   );
endinterface

// File: rtl/cube_block_sum.sv
// Accumulates a stream of unsigned cube results into per-block sums of a
// programmable length; each sum leaves on a valid/ready port with sticky carry.
module cube_block_sum #(
   parameter int DATA_W = 32,
   parameter int ACC_W  = 40,
   parameter int LEN_W  = 9
) (
   input  logic            clock,
   input  logic            reset,
   cube_block_sum_if.slave bus
);
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ACCUM = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [LEN_W-1:0] count_p0;
   logic [LEN_W-1:0] len_p0;
   logic [ACC_W-1:0] acc_p0;
   logic             ovf_p0;
   logic [ACC_W-1:0] sum_p1;
   logic             ovf_p1;
   logic             vld_p1;

   logic             accept;
   logic             first;
   logic             done;
   logic [LEN_W-1:0] eff_len;
   logic [LEN_W-1:0] count_inc;
   logic [ACC_W-1:0] acc_base;
   logic [ACC_W:0]   acc_sum;
   logic             acc_ovf;

   function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] l);
      return (l == '0) ? LEN_W'(1) : l;
   endfunction

   function automatic logic [ACC_W:0] add_wide(input logic [ACC_W-1:0] a,
                                               input logic [DATA_W-1:0] d);
      return {1'b0, a} + (ACC_W + 1)'(d);
   endfunction

   // Accumulate stage: a block's first sample ignores the stale acc/ovf.
   always_comb begin
      accept    = bus.in_valid && bus.in_ready;
      first     = (state_q != ACCUM);
      eff_len   = first ? norm_len(bus.block_len) : len_p0;
      count_inc = first ? LEN_W'(1) : count_p0 + LEN_W'(1);
      done      = accept && (count_inc == eff_len);
      acc_base  = first ? '0 : acc_p0;
      acc_sum   = add_wide(acc_base, bus.in_data);
      acc_ovf   = (!first && ovf_p0) || acc_sum[ACC_W];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (done) begin
         state_d = FULL;
      end else if (accept) begin
         state_d = ACCUM;
      end else if ((state_q == FULL) && bus.out_ready) begin
         state_d = EMPTY;
      end
   end

   always_comb begin
      vld_p1        = (state_q == FULL);
      bus.in_ready  = !vld_p1 || bus.out_ready;
      bus.out_valid = vld_p1;
      bus.out_sum   = sum_p1;
      bus.out_ovf   = ovf_p1;
   end

   // Output stage: only loaded by an accepted sample, which already implies
   // the previous result was consumed or never present.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_p0 <= '0;
         len_p0   <= LEN_W'(1);
         acc_p0   <= '0;
         ovf_p0   <= 1'b0;
         sum_p1   <= '0;
         ovf_p1   <= 1'b0;
      end else if (accept) begin
         acc_p0   <= acc_sum[ACC_W-1:0];
         ovf_p0   <= acc_ovf;
         count_p0 <= done ? '0 : count_inc;
         if (first) begin
            len_p0 <= eff_len;
         end
         if (done) begin
            sum_p1 <= acc_sum[ACC_W-1:0];
            ovf_p1 <= acc_ovf;
         end
      end
   end
endmodule

// File: tb/tb_cube_block_sum.sv
// Bench for cube_block_sum: directed table, hand-written corner sequences and
// randomized traffic scored against a true-integer block-sum model.
module tb_cube_block_sum;
   localparam int DATA_W = 32;
   localparam int ACC_W  = 40;
   localparam int LEN_W  = 9;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   cube_block_sum_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

   cube_block_sum #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int          len;
      int          n;
      logic [31:0] d [6];
      int          nexp;
      logic [39:0] s [3];
      logic        o [3];
   } vec_t;

   vec_t tbl [5];

   int checks = 0;
   int errors = 0;

   logic [39:0] got_s [$];
   logic        got_o [$];
   logic [40:0] exp_q [$];
   logic        last_in_ready;

   int          m_cnt = 0;
   int          m_len = 1;
   bit   [63:0] m_sum = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   // Reference: whole-block integer sum; overflow iff true sum reaches 2^40.
   task automatic model_accept(input logic [31:0] din, input logic [LEN_W-1:0] bl);
      if (m_cnt == 0) begin
         m_len = (bl == 0) ? 1 : int'(bl);
         m_sum = 0;
      end
      m_sum += 64'(din);
      m_cnt++;
      if (m_cnt == m_len) begin
         exp_q.push_back({(m_sum >= 64'h100_0000_0000), m_sum[39:0]});
         m_cnt = 0;
      end
   endtask

   task automatic tick();
      logic [40:0] e;
      #1;
      last_in_ready = bus.in_ready;
      if (reset) begin
         m_cnt = 0;
         exp_q.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            got_s.push_back(bus.out_sum);
            got_o.push_back(bus.out_ovf);
            if (exp_q.size() == 0) begin
               chk("scoreboard_extra_output", 64'(bus.out_sum), 64'hDEAD);
            end else begin
               e = exp_q.pop_front();
               chk("scoreboard", 64'({bus.out_ovf, bus.out_sum}), 64'(e));
            end
         end
         if (bus.in_valid && bus.in_ready) model_accept(bus.in_data, bus.block_len);
      end
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      tick();
      chk("rst_out_valid", 64'(bus.out_valid), 0);
      chk("rst_out_sum", 64'(bus.out_sum), 0);
      chk("rst_out_ovf", 64'(bus.out_ovf), 0);
      chk("rst_in_ready", 64'(bus.in_ready), 1);
      reset = 1'b0;
      got_s.delete();
      got_o.delete();
   endtask

   task automatic send(input logic [31:0] d);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      tick();
      bus.in_valid = 1'b0;
   endtask

   function automatic longint cube_sum_cf(input longint n);
      return (n * (n + 1) / 2) * (n * (n + 1) / 2);
   endfunction

   initial begin
      int leff;
      logic pv, pr, prst, po;
      logic [39:0] ps;

      tbl[0].len = 4; tbl[0].n = 4; tbl[0].d = '{1, 8, 27, 64, 0, 0};
      tbl[0].nexp = 1; tbl[0].s = '{40'd100, 0, 0}; tbl[0].o = '{0, 0, 0};
      tbl[1].len = 0; tbl[1].n = 3; tbl[1].d = '{5, 7, 9, 0, 0, 0};
      tbl[1].nexp = 3; tbl[1].s = '{40'd5, 40'd7, 40'd9}; tbl[1].o = '{0, 0, 0};
      tbl[2].len = 1; tbl[2].n = 3; tbl[2].d = '{5, 7, 9, 0, 0, 0};
      tbl[2].nexp = 3; tbl[2].s = '{40'd5, 40'd7, 40'd9}; tbl[2].o = '{0, 0, 0};
      tbl[3].len = 2; tbl[3].n = 4; tbl[3].d = '{8, 27, 64, 125, 0, 0};
      tbl[3].nexp = 2; tbl[3].s = '{40'd35, 40'd189, 0}; tbl[3].o = '{0, 0, 0};
      tbl[4].len = 2; tbl[4].n = 4; tbl[4].d = '{3, 4, 32'hFFFF_FFFF, 1, 0, 0};
      tbl[4].nexp = 2; tbl[4].s = '{40'd7, 40'h01_0000_0000, 0}; tbl[4].o = '{0, 0, 0};

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.block_len = '0;
      bus.out_ready = 1'b1;
      @(negedge clock);

      for (int v = 0; v < 5; v++) begin
         do_reset();
         bus.block_len = LEN_W'(tbl[v].len);
         leff = (tbl[v].len == 0) ? 1 : tbl[v].len;
         for (int i = 0; i < tbl[v].n; i++) begin
            send(tbl[v].d[i]);
            chk($sformatf("tbl%0d_latency_%0d", v, i), 64'(bus.out_valid),
                64'(((i + 1) % leff) == 0));
         end
         tick();
         chk($sformatf("tbl%0d_valid_drops", v), 64'(bus.out_valid), 0);
         chk($sformatf("tbl%0d_count", v), 64'(got_s.size()), 64'(tbl[v].nexp));
         for (int k = 0; k < tbl[v].nexp && k < got_s.size(); k++) begin
            chk($sformatf("tbl%0d_sum_%0d", v, k), 64'(got_s[k]), 64'(tbl[v].s[k]));
            chk($sformatf("tbl%0d_ovf_%0d", v, k), 64'(got_o[k]), 64'(tbl[v].o[k]));
         end
      end

      // Streaming n^3 with the closed-form block sums.
      do_reset();
      bus.block_len = 9'd10;
      for (int n = 1; n <= 20; n++) begin
         send(32'(n * n * n));
         chk("stream_in_ready", 64'(last_in_ready), 1);
      end
      tick();
      chk("stream_count", 64'(got_s.size()), 2);
      if (got_s.size() == 2) begin
         chk("stream_sum0", 64'(got_s[0]), 64'(cube_sum_cf(10)));
         chk("stream_sum1", 64'(got_s[1]), 64'(cube_sum_cf(20) - cube_sum_cf(10)));
      end

      // Back-pressure holds the result and blocks the input.
      do_reset();
      bus.block_len = 9'd2;
      send(8);
      send(27);
      chk("bp_first_valid", 64'(bus.out_valid), 1);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 64;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("bp_in_ready", 64'(last_in_ready), 0);
         chk("bp_hold_valid", 64'(bus.out_valid), 1);
         chk("bp_hold_sum", 64'(bus.out_sum), 35);
      end
      bus.out_ready = 1'b1;
      tick();
      chk("bp_accept_on_ready", 64'(last_in_ready), 1);
      chk("bp_mid_valid", 64'(bus.out_valid), 0);
      send(125);
      chk("bp_second_valid", 64'(bus.out_valid), 1);
      chk("bp_second_sum", 64'(bus.out_sum), 189);
      tick();

      // Overflow across a long block, then a clean short block.
      do_reset();
      bus.block_len = 9'd257;
      for (int i = 0; i < 257; i++) send(32'hFFFF_FFFF);
      chk("ovf_valid", 64'(bus.out_valid), 1);
      chk("ovf_sum", 64'(bus.out_sum), 64'h00_FFFF_FEFF);
      chk("ovf_flag", 64'(bus.out_ovf), 1);
      bus.block_len = 9'd2;
      send(1);
      send(1);
      chk("ovf_next_sum", 64'(bus.out_sum), 2);
      chk("ovf_next_flag", 64'(bus.out_ovf), 0);
      tick();

      // Reset mid-block discards the partial sum.
      do_reset();
      bus.block_len = 9'd4;
      send(1);
      send(8);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      send(27);
      chk("rmb_valid0", 64'(bus.out_valid), 0);
      send(64);
      chk("rmb_valid1", 64'(bus.out_valid), 0);
      send(125);
      chk("rmb_valid2", 64'(bus.out_valid), 0);
      send(216);
      chk("rmb_valid3", 64'(bus.out_valid), 1);
      chk("rmb_sum", 64'(bus.out_sum), 432);
      tick();

      // Randomized traffic: block_len changes freely, random stalls and resets.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         bus.in_valid = ($urandom % 4) != 0;
         case ($urandom % 3)
            0:       bus.in_data = $urandom % 1000;
            1:       bus.in_data = 32'hFFFF_FFFF - ($urandom % 16);
            default: bus.in_data = $urandom;
         endcase
         bus.block_len = (($urandom % 16) == 0) ? 9'd300 : LEN_W'($urandom % 6);
         bus.out_ready = ($urandom % 3) != 0;
         reset         = ($urandom % 400) == 0;
         pv   = bus.out_valid;
         pr   = bus.out_ready;
         ps   = bus.out_sum;
         po   = bus.out_ovf;
         prst = reset;
         tick();
         if (pv && !pr && !prst) begin
            chk("rnd_hold_valid", 64'(bus.out_valid), 1);
            chk("rnd_hold_result", 64'({bus.out_ovf, bus.out_sum}), 64'({po, ps}));
         end
      end
      reset         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      chk("rnd_drained", 64'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cube_block_sum.md
# cube_block_sum

Downstream consumer of the pipelined cube stage: accepts the stream of 32-bit cube results and accumulates them into per-block sums of a programmable length. Each completed sum is emitted on a valid/ready output port, with a sticky overflow flag for the block. It sits between the cube pipeline output and the result sink. It also gives the bench a closed-form check: the sum of n³ for n = 1..N equals (N(N+1)/2)².

## Interface
Parameters:
- DATA_W, 32, width of incoming cube results.
- ACC_W, 40, accumulator and output sum width; must satisfy ACC_W ≥ DATA_W.
- LEN_W, 9, width of block_len.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  DATA_W  cube result, unsigned.
- block_len  in  LEN_W  samples per block, unsigned; 0 is treated as 1.
- out_valid  out  1  out_sum and out_ovf are valid.
- out_ready  in  1  downstream accepts the output.
- out_sum  out  ACC_W  block sum, mod 2^ACC_W.
- out_ovf  out  1  at least one carry out of ACC_W occurred during this block.

## Operation
- **Accept:** a sample is accepted when in_valid && in_ready.
- **in_ready:** combinational, `in_ready = !out_valid || out_ready`. No storage beyond one output register.
- **States:**
  - EMPTY: no samples accumulated.
  - ACCUM: 1 ≤ count < len.
  - FULL: out_valid=1, holding the result.
- **Block start:** on the first accepted sample of a block (count==0), block_len is latched into len (0 maps to 1).
  - block_len changes mid-block have no effect until the next block start.
- **Accumulation:**
  - acc_next = acc + zero-extend(in_data), computed at ACC_W+1 bits.
  - Bit ACC_W ORs into the sticky ovf.
  - The low ACC_W bits are kept.
  - The first sample of a block loads acc = in_data and ovf = 0; it does not add to the stale acc.
- **Block end:** when the accepted sample makes count == len:
  - out_sum and out_ovf load the final acc/ovf (including this sample);
  - out_valid = 1;
  - count returns to 0.
- **Output handshake:** out_valid && out_ready clears out_valid, unless the same cycle also completes a new block, in which case out_valid stays 1 with the new values.
- **Back-pressure:** while out_valid=1 and out_ready=0:
  - out_sum and out_ovf hold stable;
  - in_ready=0;
  - no samples are accepted.
- **Simultaneous output and input:** with out_valid=1 and out_ready=1, an incoming sample is accepted in the same cycle and begins or continues the next block.
- **Data behaviour:** arithmetic is unsigned only. in_data is never sign-extended. Samples with in_valid=0 are ignored and do not advance count.

## Timing
- **Reset values:** out_valid=0, out_sum=0, out_ovf=0, count=0, acc=0, len=1. in_ready=1 during and after reset.
- **Reset mid-block:** the partial sum is discarded. Any pending output is dropped without handshake. The first sample after reset deasserts starts a fresh block.
- **Latency:** out_valid rises on the clock edge that accepts the len-th sample, i.e. visible the cycle after that sample is presented.
- **Throughput with out_ready held high:**
  - len=1: one sum per cycle.
  - In general: one sum per len accepted samples, with no bubbles.
- **Output stability:** out_sum and out_ovf change only on a cycle where out_valid was 0, or where out_valid && out_ready.
- **Hold while stalled:** with out_ready=0, out_valid stays 1 indefinitely and never drops.

## Test plan
- **Basic block:** reset, block_len=4, in_data=1,8,27,64 on consecutive cycles, out_ready=1 → one output: out_sum=100, out_ovf=0, out_valid high for exactly 1 cycle, in the cycle after 64 is accepted.
- **Streaming from the cube stage:** block_len=10, in_data = n³ for n=1..20 back-to-back, out_ready=1 → out_sum=3025 (n=1..10), then 41075 (n=11..20); no dropped cycles; in_ready constantly 1.
- **Pass-through and zero length:**
  - block_len=0, in_data=5,7,9 → three outputs, 5, 7 and 9, each one cycle after its input.
  - block_len=1 gives the identical result.
- **Back-pressure:** block_len=2, in_data=8,27 then 64,125; out_ready=0 for 5 cycles after the first sum →
  - out_sum=35 held stable for all 5 cycles;
  - in_ready=0 for those cycles;
  - 64 is accepted on the cycle out_ready rises;
  - next out_sum=189.
- **Overflow:** block_len=257, in_data=0xFFFFFFFF ×257 → out_sum=0x00FFFFFEFF, out_ovf=1. The next block of block_len=2, in_data=1,1 → out_sum=2, out_ovf=0.
- **Reset mid-block:** block_len=4, accept 1,8, assert reset for 1 cycle, then 27,64,125,216 → single output 432; out_valid stays 0 until then.
